// File: rtl/fp_mul_writeback.sv
// Writeback stage after the FP multiplier: in-order result FIFO with single-precision
// NaN-boxing, sticky exception flag accumulation and a retire counter.
module fp_mul_writeback #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_result,
   input  logic             in_is_dp,
   input  logic [3:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_result,
   output logic             out_is_dp,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flags_clear,
   input  logic             flush,
   output logic [3:0]       fflags,
   output logic [31:0]      retire_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [63:0]      result_mem [DEPTH];
   logic             is_dp_mem  [DEPTH];
   logic [3:0]       flags_mem  [DEPTH];
   logic [TAG_W-1:0] tag_mem    [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic        push;
   logic        pop;
   logic [63:0] boxed_result;
   logic [3:0]  retire_sticky;

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);

   // A push arriving in a flush cycle is dropped; the pop in that cycle still retires.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready;

   assign boxed_result = in_is_dp ? in_result : {32'hFFFF_FFFF, in_result[31:0]};

   assign out_result = result_mem[rd_ptr];
   assign out_is_dp  = is_dp_mem[rd_ptr];
   assign out_flags  = flags_mem[rd_ptr];
   assign out_tag    = tag_mem[rd_ptr];

   // Underflow only becomes architecturally sticky when the result was also inexact.
   assign retire_sticky = {out_flags[3], out_flags[2], out_flags[1] & out_flags[0], out_flags[0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            result_mem[i] <= '0;
            is_dp_mem[i]  <= 1'b0;
            flags_mem[i]  <= '0;
            tag_mem[i]    <= '0;
         end
      end else if (push) begin
         result_mem[wr_ptr] <= boxed_result;
         is_dp_mem[wr_ptr]  <= in_is_dp;
         flags_mem[wr_ptr]  <= in_flags;
         tag_mem[wr_ptr]    <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fflags       <= '0;
         retire_count <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         fflags <= (flags_clear ? 4'b0000 : fflags) | (pop ? retire_sticky : 4'b0000);
         if (pop) retire_count <= retire_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fp_mul_writeback.sv
// Self-checking bench for fp_mul_writeback: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_fp_mul_writeback;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_result;
   logic             in_is_dp;
   logic [3:0]       in_flags;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_result;
   logic             out_is_dp;
   logic [3:0]       out_flags;
   logic [TAG_W-1:0] out_tag;
   logic             flags_clear;
   logic             flush;
   logic [3:0]       fflags;
   logic [31:0]      retire_count;

   int testsRun;
   int testsFailed;

   fp_mul_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_result(in_result),
      .in_is_dp(in_is_dp),
      .in_flags(in_flags),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_is_dp(out_is_dp),
      .out_flags(out_flags),
      .out_tag(out_tag),
      .flags_clear(flags_clear),
      .flush(flush),
      .fflags(fflags),
      .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]      res;
      logic             dp;
      logic [3:0]       fl;
      logic [TAG_W-1:0] tag;
      logic [63:0]      expRes;
   } vec_t;

   typedef struct packed {
      logic [63:0]      res;
      logic             dp;
      logic [3:0]       fl;
      logic [TAG_W-1:0] tag;
   } ent_t;

   vec_t vecs [4];
   ent_t modelQ [$];
   logic [3:0]  modelFlags;
   logic [31:0] modelRetire;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic iv, input logic [63:0] res, input logic dp,
                                input logic [3:0] fl, input logic [TAG_W-1:0] tag,
                                input logic ordy, input logic fclr, input logic fsh);
      in_valid    = iv;
      in_result   = res;
      in_is_dp    = dp;
      in_flags    = fl;
      in_tag      = tag;
      out_ready   = ordy;
      flags_clear = fclr;
      flush       = fsh;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // One-cycle push with the consumer stalled.
   task automatic pushOne(input logic [63:0] res, input logic dp, input logic [3:0] fl, input logic [TAG_W-1:0] tag);
      applyStimulus(1'b1, res, dp, fl, tag, 1'b0, 1'b0, 1'b0);
      step();
      idle();
   endtask

   task automatic popOne();
      applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, '0, 1'b1, 1'b0, 1'b0);
      step();
      idle();
   endtask

   initial begin
      logic [31:0] baseRetire;
      logic        popped;
      logic        pushed;
      logic [3:0]  nextFlags;
      ent_t        head;

      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b1;
      idle();

      vecs[0] = '{res: 64'h0000_0000_3F80_0000, dp: 1'b0, fl: 4'b0000, tag: 5'd3,  expRes: 64'hFFFF_FFFF_3F80_0000};
      vecs[1] = '{res: 64'h3FF0_0000_0000_0000, dp: 1'b1, fl: 4'b0000, tag: 5'd4,  expRes: 64'h3FF0_0000_0000_0000};
      vecs[2] = '{res: 64'hDEAD_BEEF_4049_0FDB, dp: 1'b0, fl: 4'b0001, tag: 5'd7,  expRes: 64'hFFFF_FFFF_4049_0FDB};
      vecs[3] = '{res: 64'h1234_5678_9ABC_DEF0, dp: 1'b1, fl: 4'b1000, tag: 5'd31, expRes: 64'h1234_5678_9ABC_DEF0};

      // Reset held for two cycles.
      step();
      step();
      rst = 1'b0;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_fflags", 64'(fflags), 64'd0);
      checkOutput("reset_retire_count", 64'(retire_count), 64'd0);
      checkOutput("reset_out_result", out_result, 64'd0);
      checkOutput("reset_out_tag", 64'(out_tag), 64'd0);

      // Vector table: push one entry, check head one cycle later, retire it.
      for (int i = 0; i < 4; i++) begin
         pushOne(vecs[i].res, vecs[i].dp, vecs[i].fl, vecs[i].tag);
         checkOutput("vec_out_valid", 64'(out_valid), 64'd1);
         checkOutput("vec_out_result", out_result, vecs[i].expRes);
         checkOutput("vec_out_is_dp", 64'(out_is_dp), 64'(vecs[i].dp));
         checkOutput("vec_out_flags", 64'(out_flags), 64'(vecs[i].fl));
         checkOutput("vec_out_tag", 64'(out_tag), 64'(vecs[i].tag));
         popOne();
         checkOutput("vec_empty_after_pop", 64'(out_valid), 64'd0);
      end
      checkOutput("vec_retire_count", 64'(retire_count), 64'd4);
      checkOutput("vec_fflags", 64'(fflags), 64'b1001);

      applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
      step();
      idle();
      checkOutput("clear_fflags", 64'(fflags), 64'd0);

      // Backpressure: fill, hold tag 3 at the input, then drain.
      baseRetire = retire_count;
      pushOne(64'h3FF0_0000_0000_0001, 1'b1, 4'd0, 5'd1);
      pushOne(64'h3FF0_0000_0000_0002, 1'b1, 4'd0, 5'd2);
      checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 64'h3FF0_0000_0000_0003, 1'b1, 4'd0, 5'd3, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("bp_still_full", 64'(in_ready), 64'd0);
      checkOutput("bp_head_stable", 64'(out_tag), 64'd1);
      checkOutput("bp_head_result_stable", out_result, 64'h3FF0_0000_0000_0001);
      out_ready = 1'b1;
      step();
      checkOutput("bp_second_tag", 64'(out_tag), 64'd2);
      checkOutput("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      checkOutput("bp_third_tag", 64'(out_tag), 64'd3);
      checkOutput("bp_third_valid", 64'(out_valid), 64'd1);
      step();
      idle();
      checkOutput("bp_drained", 64'(out_valid), 64'd0);
      checkOutput("bp_retire_count", 64'(retire_count), 64'(baseRetire + 32'd3));

      // Underflow stickiness needs inexact too.
      pushOne(64'd1, 1'b1, 4'b0010, 5'd5);
      checkOutput("uf_raw_out_flags", 64'(out_flags), 64'b0010);
      popOne();
      checkOutput("uf_only_fflags", 64'(fflags), 64'b0000);
      pushOne(64'd2, 1'b1, 4'b0011, 5'd6);
      popOne();
      checkOutput("uf_nx_fflags", 64'(fflags), 64'b0011);
      pushOne(64'd3, 1'b1, 4'b1000, 5'd7);
      popOne();
      checkOutput("nv_fflags", 64'(fflags), 64'b1011);

      // Clear in the same cycle as a retire: the retiring flags survive.
      applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
      step();
      idle();
      pushOne(64'd4, 1'b1, 4'b0101, 5'd8);
      popOne();
      checkOutput("setup_0101", 64'(fflags), 64'b0101);
      pushOne(64'd5, 1'b1, 4'b1000, 5'd9);
      applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, '0, 1'b1, 1'b1, 1'b0);
      step();
      idle();
      checkOutput("clear_vs_retire", 64'(fflags), 64'b1000);

      // Flush with a concurrent pop and push.
      baseRetire = retire_count;
      pushOne(64'd10, 1'b1, 4'b0000, 5'd10);
      pushOne(64'd11, 1'b1, 4'b1111, 5'd11);
      applyStimulus(1'b1, 64'd12, 1'b1, 4'b1111, 5'd12, 1'b1, 1'b0, 1'b1);
      step();
      idle();
      checkOutput("flush_retire_count", 64'(retire_count), 64'(baseRetire + 32'd1));
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      checkOutput("flush_fflags", 64'(fflags), 64'b1000);
      step();
      checkOutput("flush_push_dropped", 64'(out_valid), 64'd0);

      // Randomized run against a queue model, starting from reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      modelQ.delete();
      modelFlags  = 4'd0;
      modelRetire = 32'd0;
      for (int c = 0; c < 3000; c++) begin
         checkOutput("rnd_out_valid", 64'(out_valid), 64'(modelQ.size() != 0));
         checkOutput("rnd_in_ready", 64'(in_ready), 64'(modelQ.size() != DEPTH));
         checkOutput("rnd_fflags", 64'(fflags), 64'(modelFlags));
         checkOutput("rnd_retire_count", 64'(retire_count), 64'(modelRetire));
         if (modelQ.size() != 0) begin
            checkOutput("rnd_out_result", out_result, modelQ[0].res);
            checkOutput("rnd_out_is_dp", 64'(out_is_dp), 64'(modelQ[0].dp));
            checkOutput("rnd_out_flags", 64'(out_flags), 64'(modelQ[0].fl));
            checkOutput("rnd_out_tag", 64'(out_tag), 64'(modelQ[0].tag));
         end

         rst = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 2) != 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 31)),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 29) == 0);

         if (rst) begin
            modelQ.delete();
            modelFlags  = 4'd0;
            modelRetire = 32'd0;
         end else begin
            popped    = (modelQ.size() != 0) && out_ready;
            pushed    = in_valid && (modelQ.size() < DEPTH) && !flush;
            nextFlags = flags_clear ? 4'd0 : modelFlags;
            if (popped) begin
               head = modelQ.pop_front();
               nextFlags = nextFlags | {head.fl[3], head.fl[2], head.fl[1] & head.fl[0], head.fl[0]};
               modelRetire = modelRetire + 32'd1;
            end
            modelFlags = nextFlags;
            if (flush) modelQ.delete();
            if (pushed)
               modelQ.push_back('{res: in_is_dp ? in_result : {32'hFFFF_FFFF, in_result[31:0]},
                                  dp: in_is_dp, fl: in_flags, tag: in_tag});
         end
         step();
      end
      rst = 1'b0;
      idle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
